// File: rtl/sensor_command_pkg.sv
// Shared definitions for the host command path that sits behind the UART
// receiver: assembler state encoding, request-code constants, default
// legality limits and the command field width.
package sensor_command_pkg;

   // Assembler FSM states.
   typedef enum logic [1:0] {
      WAIT_CODE    = 2'd0,
      WAIT_ADDRESS = 2'd1,
      HOLD         = 2'd2
   } assembler_state_t;

   // Width of the code and address fields of a command.
   localparam int unsigned COMMAND_WIDTH = 8;

   // Request codes understood by the sensor controller.
   localparam logic [COMMAND_WIDTH-1:0] REQ_STATUS                = 8'h00;
   localparam logic [COMMAND_WIDTH-1:0] REQ_TEMPERATURE           = 8'h01;
   localparam logic [COMMAND_WIDTH-1:0] REQ_HUMIDITY              = 8'h02;
   localparam logic [COMMAND_WIDTH-1:0] REQ_TEMPERATURE_CONT_START = 8'h03;
   localparam logic [COMMAND_WIDTH-1:0] REQ_TEMPERATURE_CONT_STOP  = 8'h04;
   localparam logic [COMMAND_WIDTH-1:0] REQ_HUMIDITY_CONT_START    = 8'h05;
   localparam logic [COMMAND_WIDTH-1:0] REQ_HUMIDITY_CONT_STOP     = 8'h06;

   // Default legality limits: every defined request, 32 sensor addresses.
   localparam logic [COMMAND_WIDTH-1:0] DEFAULT_MAX_CODE    = REQ_HUMIDITY_CONT_STOP;
   localparam logic [COMMAND_WIDTH-1:0] DEFAULT_MAX_ADDRESS = 8'h1F;

   // A frame is legal when both fields are within their (unsigned) limits.
   function automatic logic frame_is_legal(
      input logic [COMMAND_WIDTH-1:0] code,
      input logic [COMMAND_WIDTH-1:0] address,
      input logic [COMMAND_WIDTH-1:0] max_code,
      input logic [COMMAND_WIDTH-1:0] max_address
   );
      return (code <= max_code) && (address <= max_address);
   endfunction

endpackage

// File: rtl/interbyte_timer.sv
// Saturating inter-byte timer.
// Ports:
//   clock    - system clock
//   reset_n  - asynchronous active-low reset, count returns to 0
//   clear    - synchronous clear to 0 (has priority over enable)
//   enable   - advance the count by one this cycle
//   expired  - count has reached TIMEOUT_CLOCKS-1 (held there, never wraps)
// TIMEOUT_CLOCKS must be at least 2 so that the terminal count is non-zero.
module interbyte_timer #(
   parameter int unsigned TIMEOUT_CLOCKS = 3480
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned COUNT_WIDTH = $clog2(TIMEOUT_CLOCKS);
   localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(TIMEOUT_CLOCKS - 1);

   logic [COUNT_WIDTH-1:0] count_q;
   logic [COUNT_WIDTH-1:0] count_d;

   assign expired = (count_q == LAST_COUNT);

   // Stop advancing once the terminal count is reached so the flag stays up.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !expired) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/uart_command_assembler.sv
// Assembles the two-byte host command (request code, then sensor address)
// from the UART receiver's byte strobe, validates it and hands it to the
// sensor controller over a valid/ready handshake.
// Ports:
//   clock, reset_n     - system clock, asynchronous active-low reset
//   has_data           - one-cycle strobe, data_received holds a new byte
//   data_received      - received byte
//   command_ready      - downstream accepts the presented command
//   command_valid      - command presented, held until accepted
//   command_code       - request code of the presented command
//   sensor_address     - sensor address of the presented command
//   frame_error        - one-cycle pulse, completed frame was illegal
//   timeout_error      - one-cycle pulse, address byte never arrived
//   overrun_error      - one-cycle pulse, byte dropped while holding a command
module uart_command_assembler
   import sensor_command_pkg::*;
#(
   parameter int unsigned               TIMEOUT_CLOCKS = 3480,
   parameter logic [COMMAND_WIDTH-1:0]  MAX_CODE       = DEFAULT_MAX_CODE,
   parameter logic [COMMAND_WIDTH-1:0]  MAX_ADDRESS    = DEFAULT_MAX_ADDRESS
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     has_data,
   input  logic [COMMAND_WIDTH-1:0] data_received,
   input  logic                     command_ready,
   output logic                     command_valid,
   output logic [COMMAND_WIDTH-1:0] command_code,
   output logic [COMMAND_WIDTH-1:0] sensor_address,
   output logic                     frame_error,
   output logic                     timeout_error,
   output logic                     overrun_error
);

   assembler_state_t          state_q, state_d;
   logic [COMMAND_WIDTH-1:0]  code_q, code_d;
   logic [COMMAND_WIDTH-1:0]  address_q, address_d;
   logic                      valid_q, valid_d;
   logic                      frame_error_q, frame_error_d;
   logic                      timeout_error_q, timeout_error_d;
   logic                      overrun_error_q, overrun_error_d;

   logic timer_clear;
   logic timer_enable;
   logic timer_expired;
   logic transfer;

   // The timer only runs while waiting for the address; it is held at zero
   // in every other state, so it always starts fresh on entering WAIT_ADDRESS.
   assign timer_clear  = (state_q != WAIT_ADDRESS);
   assign timer_enable = (state_q == WAIT_ADDRESS);

   interbyte_timer #(
      .TIMEOUT_CLOCKS (TIMEOUT_CLOCKS)
   ) u_interbyte_timer (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (timer_clear),
      .enable  (timer_enable),
      .expired (timer_expired)
   );

   assign transfer = valid_q && command_ready;

   // Next-state logic. Error pulses default low so each lasts one cycle, and
   // at most one of them can be raised per cycle by construction.
   always_comb begin
      state_d         = state_q;
      code_d          = code_q;
      address_d       = address_q;
      valid_d         = valid_q;
      frame_error_d   = 1'b0;
      timeout_error_d = 1'b0;
      overrun_error_d = 1'b0;

      unique case (state_q)
         WAIT_CODE: begin
            if (has_data) begin
               code_d  = data_received;
               state_d = WAIT_ADDRESS;
            end
         end

         WAIT_ADDRESS: begin
            // A byte arriving in the expiry cycle still counts as the address.
            if (has_data) begin
               address_d = data_received;
               if (frame_is_legal(code_q, data_received, MAX_CODE, MAX_ADDRESS)) begin
                  valid_d = 1'b1;
                  state_d = HOLD;
               end else begin
                  frame_error_d = 1'b1;
                  state_d       = WAIT_CODE;
               end
            end else if (timer_expired) begin
               timeout_error_d = 1'b1;
               code_d          = '0;
               state_d         = WAIT_CODE;
            end
         end

         HOLD: begin
            // A byte coincident with the transfer is the next frame's code.
            if (transfer) begin
               valid_d = 1'b0;
               if (has_data) begin
                  code_d  = data_received;
                  state_d = WAIT_ADDRESS;
               end else begin
                  state_d = WAIT_CODE;
               end
            end else if (has_data) begin
               overrun_error_d = 1'b1;
            end
         end

         default: begin
            valid_d = 1'b0;
            state_d = WAIT_CODE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= WAIT_CODE;
         code_q          <= '0;
         address_q       <= '0;
         valid_q         <= 1'b0;
         frame_error_q   <= 1'b0;
         timeout_error_q <= 1'b0;
         overrun_error_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         code_q          <= code_d;
         address_q       <= address_d;
         valid_q         <= valid_d;
         frame_error_q   <= frame_error_d;
         timeout_error_q <= timeout_error_d;
         overrun_error_q <= overrun_error_d;
      end
   end

   assign command_valid  = valid_q;
   assign command_code   = code_q;
   assign sensor_address = address_q;
   assign frame_error    = frame_error_q;
   assign timeout_error  = timeout_error_q;
   assign overrun_error  = overrun_error_q;

endmodule

// File: tb/tb_uart_command_assembler.sv
// Testbench for uart_command_assembler: directed vector table, hand-written
// timeout/reset sequences and a randomized run against a frame-level model.
module tb_uart_command_assembler;

   localparam int TOUT = 20;
   localparam logic [7:0] MAXC = 8'h06;
   localparam logic [7:0] MAXA = 8'h1F;

   logic       clock;
   logic       reset_n;
   logic       has_data;
   logic [7:0] data_received;
   logic       command_ready;
   logic       command_valid;
   logic [7:0] command_code;
   logic [7:0] sensor_address;
   logic       frame_error;
   logic       timeout_error;
   logic       overrun_error;

   int checks = 0;
   int errors = 0;

   uart_command_assembler #(
      .TIMEOUT_CLOCKS (TOUT),
      .MAX_CODE       (MAXC),
      .MAX_ADDRESS    (MAXA)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .has_data       (has_data),
      .data_received  (data_received),
      .command_ready  (command_ready),
      .command_valid  (command_valid),
      .command_code   (command_code),
      .sensor_address (sensor_address),
      .frame_error    (frame_error),
      .timeout_error  (timeout_error),
      .overrun_error  (overrun_error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic       hd;
      logic [7:0] d;
      logic       rdy;
      logic       expValid;
      logic [7:0] expCode;
      logic [7:0] expAddr;
      logic       expFrame;
      logic       expTimeout;
      logic       expOverrun;
   } vector_t;

   vector_t vectors[$];
   vector_t v;

   // Frame-level reference model: a pending-command flag, an optional held
   // code byte and the cycle number at which that code arrived.
   int         mCycle;
   int         mCodeCycle;
   bit         mHaveCode;
   logic [7:0] mCode;
   bit         mPending;
   logic [7:0] mOutCode;
   logic [7:0] mOutAddr;
   bit         mFrame;
   bit         mTimeout;
   bit         mOverrun;

   logic       rHd;
   logic [7:0] rData;
   logic       rRdy;
   int         mode;
   int         hdChance;

   task automatic addVec(input logic hd, input logic [7:0] d, input logic rdy,
                         input logic ev, input logic [7:0] ec, input logic [7:0] ea,
                         input logic ef, input logic et, input logic eo);
      vector_t t;
      t.hd = hd; t.d = d; t.rdy = rdy;
      t.expValid = ev; t.expCode = ec; t.expAddr = ea;
      t.expFrame = ef; t.expTimeout = et; t.expOverrun = eo;
      vectors.push_back(t);
   endtask

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkAll(input string tag, input logic ev, input logic [7:0] ec, input logic [7:0] ea,
                           input logic ef, input logic et, input logic eo);
      checkOutput({tag, ".valid"}, {7'd0, command_valid}, {7'd0, ev});
      checkOutput({tag, ".frame"}, {7'd0, frame_error}, {7'd0, ef});
      checkOutput({tag, ".timeout"}, {7'd0, timeout_error}, {7'd0, et});
      checkOutput({tag, ".overrun"}, {7'd0, overrun_error}, {7'd0, eo});
      if (ev) begin
         checkOutput({tag, ".code"}, command_code, ec);
         checkOutput({tag, ".addr"}, sensor_address, ea);
      end
   endtask

   // Drive one cycle of inputs, let a rising edge pass, return 1 unit later.
   task automatic applyStimulus(input logic hd, input logic [7:0] d, input logic rdy);
      has_data      = hd;
      data_received = d;
      command_ready = rdy;
      @(posedge clock);
      #1;
   endtask

   task automatic pulseReset();
      #2 reset_n = 1'b0;
      #1;
   endtask

   task automatic releaseReset();
      has_data = 1'b0;
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic checkCleared(input string tag);
      checkOutput({tag, ".valid"}, {7'd0, command_valid}, 8'd0);
      checkOutput({tag, ".code"}, command_code, 8'd0);
      checkOutput({tag, ".addr"}, sensor_address, 8'd0);
      checkOutput({tag, ".errs"}, {5'd0, frame_error, timeout_error, overrun_error}, 8'd0);
   endtask

   task automatic modelReset();
      mCycle = 0; mCodeCycle = 0; mHaveCode = 0; mCode = 8'h00;
      mPending = 0; mOutCode = 8'h00; mOutAddr = 8'h00;
      mFrame = 0; mTimeout = 0; mOverrun = 0;
   endtask

   task automatic modelStep(input logic hd, input logic [7:0] d, input logic rdy);
      mFrame = 0; mTimeout = 0; mOverrun = 0;
      mCycle++;
      if (mPending) begin
         if (rdy) begin
            mPending = 0;
            if (hd) begin
               mHaveCode = 1; mCode = d; mCodeCycle = mCycle;
            end
         end else if (hd) begin
            mOverrun = 1;
         end
      end else if (!mHaveCode) begin
         if (hd) begin
            mHaveCode = 1; mCode = d; mCodeCycle = mCycle;
         end
      end else if (hd) begin
         mHaveCode = 0;
         if (mCode <= MAXC && d <= MAXA) begin
            mPending = 1; mOutCode = mCode; mOutAddr = d;
         end else begin
            mFrame = 1;
         end
      end else if (mCycle - mCodeCycle == TOUT) begin
         mTimeout = 1;
         mHaveCode = 0;
      end
   endtask

   initial begin
      reset_n       = 1'b0;
      has_data      = 1'b0;
      data_received = 8'h00;
      command_ready = 1'b0;
      #23;
      checkCleared("reset");
      @(negedge clock);
      reset_n = 1'b1;

      // hd, data, ready | valid, code, addr, frame, timeout, overrun
      addVec(1, 8'h03, 1,  0, 8'h00, 8'h00, 0, 0, 0);
      addVec(1, 8'h05, 1,  1, 8'h03, 8'h05, 0, 0, 0);
      addVec(0, 8'h00, 1,  0, 8'h00, 8'h00, 0, 0, 0);
      addVec(1, 8'h07, 0,  0, 8'h00, 8'h00, 0, 0, 0);
      addVec(1, 8'h01, 0,  0, 8'h00, 8'h00, 1, 0, 0);
      addVec(0, 8'h00, 0,  0, 8'h00, 8'h00, 0, 0, 0);
      addVec(1, 8'h00, 0,  0, 8'h00, 8'h00, 0, 0, 0);
      addVec(1, 8'h1F, 0,  1, 8'h00, 8'h1F, 0, 0, 0);
      addVec(0, 8'h00, 0,  1, 8'h00, 8'h1F, 0, 0, 0);
      addVec(0, 8'h00, 1,  0, 8'h00, 8'h00, 0, 0, 0);
      addVec(1, 8'h04, 0,  0, 8'h00, 8'h00, 0, 0, 0);
      addVec(1, 8'h10, 0,  1, 8'h04, 8'h10, 0, 0, 0);
      addVec(0, 8'h00, 0,  1, 8'h04, 8'h10, 0, 0, 0);
      addVec(1, 8'hAA, 0,  1, 8'h04, 8'h10, 0, 0, 1);
      addVec(0, 8'h00, 0,  1, 8'h04, 8'h10, 0, 0, 0);
      addVec(0, 8'h00, 1,  0, 8'h00, 8'h00, 0, 0, 0);
      addVec(1, 8'h05, 0,  0, 8'h00, 8'h00, 0, 0, 0);
      addVec(1, 8'h03, 0,  1, 8'h05, 8'h03, 0, 0, 0);
      addVec(1, 8'h02, 1,  0, 8'h00, 8'h00, 0, 0, 0);
      addVec(1, 8'h08, 0,  1, 8'h02, 8'h08, 0, 0, 0);
      addVec(0, 8'h00, 1,  0, 8'h00, 8'h00, 0, 0, 0);
      addVec(1, 8'h06, 0,  0, 8'h00, 8'h00, 0, 0, 0);
      addVec(1, 8'h20, 0,  0, 8'h00, 8'h00, 1, 0, 0);
      addVec(1, 8'h06, 1,  0, 8'h00, 8'h00, 0, 0, 0);
      addVec(1, 8'h1F, 1,  1, 8'h06, 8'h1F, 0, 0, 0);
      addVec(0, 8'h00, 1,  0, 8'h00, 8'h00, 0, 0, 0);

      for (int i = 0; i < vectors.size(); i++) begin
         v = vectors[i];
         applyStimulus(v.hd, v.d, v.rdy);
         checkAll($sformatf("vec%0d", i), v.expValid, v.expCode, v.expAddr,
                  v.expFrame, v.expTimeout, v.expOverrun);
      end

      // Silence after a code byte: timeout exactly TOUT edges after the code.
      applyStimulus(1, 8'h01, 0);
      checkAll("to.code", 0, 8'h00, 8'h00, 0, 0, 0);
      for (int k = 1; k < TOUT; k++) begin
         applyStimulus(0, 8'h00, 0);
         checkAll($sformatf("to.wait%0d", k), 0, 8'h00, 8'h00, 0, 0, 0);
      end
      applyStimulus(0, 8'h00, 0);
      checkAll("to.fire", 0, 8'h00, 8'h00, 0, 1, 0);
      applyStimulus(0, 8'h00, 0);
      checkAll("to.after", 0, 8'h00, 8'h00, 0, 0, 0);
      applyStimulus(1, 8'h02, 1);
      checkAll("to.next.code", 0, 8'h00, 8'h00, 0, 0, 0);
      applyStimulus(1, 8'h00, 1);
      checkAll("to.next.cmd", 1, 8'h02, 8'h00, 0, 0, 0);
      applyStimulus(0, 8'h00, 1);
      checkAll("to.next.done", 0, 8'h00, 8'h00, 0, 0, 0);

      // Address arriving in the very cycle the timer would expire.
      applyStimulus(1, 8'h03, 0);
      for (int k = 1; k < TOUT; k++) applyStimulus(0, 8'h00, 0);
      applyStimulus(1, 8'h07, 0);
      checkAll("edge.cmd", 1, 8'h03, 8'h07, 0, 0, 0);
      applyStimulus(0, 8'h00, 1);
      checkAll("edge.done", 0, 8'h00, 8'h00, 0, 0, 0);

      // Asynchronous reset while waiting for the address.
      applyStimulus(1, 8'h01, 0);
      pulseReset();
      checkCleared("rst.waddr");
      releaseReset();
      applyStimulus(1, 8'h02, 0);
      applyStimulus(1, 8'h03, 0);
      checkAll("rst.fresh1", 1, 8'h02, 8'h03, 0, 0, 0);
      applyStimulus(0, 8'h00, 0);
      // Asynchronous reset while holding a command.
      pulseReset();
      checkCleared("rst.hold");
      releaseReset();
      applyStimulus(1, 8'h04, 1);
      checkAll("rst.fresh2.code", 0, 8'h00, 8'h00, 0, 0, 0);
      applyStimulus(1, 8'h05, 1);
      checkAll("rst.fresh2.cmd", 1, 8'h04, 8'h05, 0, 0, 0);
      applyStimulus(0, 8'h00, 1);
      checkAll("rst.fresh2.done", 0, 8'h00, 8'h00, 0, 0, 0);

      // Randomized traffic with quiet, normal and dense phases.
      pulseReset();
      releaseReset();
      modelReset();
      mode = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 150 == 0) mode = $urandom_range(0, 2);
         hdChance = (mode == 0) ? 33 : (mode == 1) ? 3 : 80;
         rHd  = ($urandom_range(0, 99) < hdChance);
         rRdy = ($urandom_range(0, 1) == 1);
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: rData = 8'($urandom_range(0, 8));
            5, 6, 7, 8:    rData = 8'($urandom_range(0, 34));
            default:       rData = 8'($urandom_range(0, 255));
         endcase
         has_data      = rHd;
         data_received = rData;
         command_ready = rRdy;
         @(posedge clock);
         modelStep(rHd, rData, rRdy);
         #1;
         checkAll($sformatf("rnd%0d", i), mPending, mOutCode, mOutAddr, mFrame, mTimeout, mOverrun);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_command_assembler.md
# uart_command_assembler

Downstream consumer of the 8N1 UART receiver. It collects the two-byte host command frame (request code, then sensor address) from the receiver's one-cycle `has_data` strobe and `data_received` byte, and enforces an inter-byte timeout. It validates the frame and presents a complete command to the sensor controller over a valid/ready handshake.

## Interface
Parameters:
- `TIMEOUT_CLOCKS`, default 3480: inter-byte timeout in clocks (4 byte-times at 87 clocks/bit × 10 bits); must be ≥ 2.
- `MAX_CODE`, default 8'h06: highest legal request code.
- `MAX_ADDRESS`, default 8'h1F: highest legal sensor address.

Ports:
- `clock`  in  1  system clock, all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `has_data`  in  1  one-cycle strobe from the UART receiver: byte available.
- `data_received`  in  8  received byte, valid when `has_data`=1.
- `command_ready`  in  1  downstream can accept a command.
- `command_valid`  out  1  command presented; held until accepted.
- `command_code`  out  8  request code of the presented command.
- `sensor_address`  out  8  sensor address of the presented command.
- `frame_error`  out  1  one-cycle pulse: completed frame had an illegal code or address.
- `timeout_error`  out  1  one-cycle pulse: address byte not received in time.
- `overrun_error`  out  1  one-cycle pulse: byte dropped while a command was pending.

## Operation
- States: WAIT_CODE, WAIT_ADDRESS, HOLD.
- WAIT_CODE: on `has_data`, latch the byte into the code register, clear the timer, and go to WAIT_ADDRESS. Code legality is not checked yet.
- WAIT_ADDRESS:
  - Timer increments every cycle.
  - On `has_data`, latch the address.
  - If code ≤ MAX_CODE and address ≤ MAX_ADDRESS, go to HOLD with `command_valid`=1.
  - Otherwise pulse `frame_error` and go to WAIT_CODE. The frame is consumed, so alignment is preserved.
  - If the timer reaches TIMEOUT_CLOCKS−1 with no `has_data`, pulse `timeout_error`, discard the code, and go to WAIT_CODE.
  - `has_data` in the expiry cycle: the byte wins and is taken as the address; no timeout is reported.
- HOLD: `command_valid`, `command_code` and `sensor_address` stay stable until `command_valid && command_ready` is sampled at a rising edge (the transfer).
  - After the transfer, go to WAIT_CODE.
  - `has_data` in HOLD without a transfer: byte dropped, `overrun_error` pulses.
  - `has_data` in the transfer cycle: byte latched as the next code, go directly to WAIT_ADDRESS, no overrun.
- Comparisons are unsigned 8-bit. Timer width is $clog2(TIMEOUT_CLOCKS); it saturates and never wraps.

## Timing
- Reset values: state WAIT_CODE; `command_valid`, all error pulses, `command_code`, `sensor_address` and the timer are 0.
- Reset asserted mid-frame or in HOLD: everything clears immediately and the pending command is lost. The first `has_data` after release is a code byte.
- Address `has_data` at edge N → `command_valid` (or `frame_error`) high after edge N+1, i.e. 1-cycle latency.
- `command_valid` is registered with no combinational path from `command_ready`. If ready is already high, valid lasts exactly one cycle.
- Error outputs are registered, high for exactly one cycle, and mutually exclusive in any cycle.
- Timeout: code `has_data` at edge N, no further byte → `timeout_error` high for the cycle after edge N+TIMEOUT_CLOCKS.
- Back-to-back `has_data` on consecutive cycles is legal at this input; the UART never produces it, but the block must handle it.

## Structure
- Shared package `sensor_command_pkg`:
  - state encoding;
  - request-code constants (0x00 status … 0x06 humidity continuous-stop);
  - default MAX_CODE/MAX_ADDRESS;
  - command width constant.
- One sub-module `interbyte_timer`: clear/enable inputs, saturating counter, `expired` output, parameterised by TIMEOUT_CLOCKS.
- Remaining FSM and registers in the top module.

## Test plan
- Code 0x03 then address 0x05, ready held high → one-cycle `command_valid` with code 0x03, address 0x05; no errors.
- Code 0x07 then address 0x01 → single `frame_error` pulse, no valid. A following 0x00/0x1F frame is accepted correctly.
- Code 0x01, then silence for TIMEOUT_CLOCKS → `timeout_error` at exactly N+TIMEOUT_CLOCKS. A following 0x02/0x00 frame is accepted.
- Frame 0x04/0x10 with ready low; third byte 0xAA arrives → `overrun_error` pulse; outputs stay 0x04/0x10. Ready raised → transfer.
- In HOLD, ready and `has_data`(0x02) in the same cycle → transfer, then 0x02 treated as code; address 0x08 → command 0x02/0x08.
- `reset_n` pulsed low in WAIT_ADDRESS and in HOLD → outputs 0 asynchronously. The next two bytes form a fresh frame.
